// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;
    typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} muldiv_op_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    localparam int MUL_STAGES_DEF = 2;
    // Divide by zero: lo is filled with this bit, hi returns the raw dividend.
    localparam logic DIV0_LO_BIT = 1'b1;
endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// hilo_muldiv_div_iter: unsigned restoring divider, one quotient bit per cycle.
module hilo_muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   trial;
    // A set top bit of the trial subtraction means the divisor did not fit.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        valid = run_q && cnt_q == CW'(WIDTH);
    end
    assign quot = quo_q;
    assign rem  = rem_q;
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (valid) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO registers with pipelined multiplier and iterative divider.
// Define HILO_FWD_EN to forward same-cycle direct writes onto the hi/lo outputs.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = MUL_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MUL_STAGES + 1);
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q [MUL_STAGES];
    logic [2*WIDTH-1:0] ax, bx;
    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem, a_q;
    logic [WIDTH-1:0]   res_hi, res_lo, hi_q, hi_d, lo_q, lo_d;
    logic               accept, is_mul, a_neg, b_neg, mul_last, div_last, div_valid, commit;
    logic               negq_q, negr_q, dz_q, done_q;
    always_comb begin
        is_mul = op == MULT || op == MULTU;
        a_neg  = op == DIV && a[WIDTH-1];
        b_neg  = op == DIV && b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        ax     = op == MULT ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        bx     = op == MULT ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        accept = start && !busy && !flush;
    end
    hilo_muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk(clk), .reset(reset), .load(accept && !is_mul), .abort(flush),
        .dividend(a_mag), .divisor(b_mag), .quot(quot), .rem(rem), .valid(div_valid)
    );
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        mul_last = state_q == S_MUL && cnt_q == CW'(MUL_STAGES - 1);
        div_last = state_q == S_DIV && div_valid;
        state_d  = (flush || mul_last || div_last) ? S_IDLE
                 : accept ? (is_mul ? S_MUL : S_DIV) : state_q;
    end
    // A flush on the last busy cycle suppresses the commit; direct writes win per half.
    always_comb begin
        commit = (mul_last || div_last) && !flush;
        res_lo = state_q == S_MUL ? prod_q[MUL_STAGES-1][WIDTH-1:0]
               : dz_q ? {WIDTH{DIV0_LO_BIT}} : negq_q ? -quot : quot;
        res_hi = state_q == S_MUL ? prod_q[MUL_STAGES-1][2*WIDTH-1:WIDTH]
               : dz_q ? a_q : negr_q ? -rem : rem;
        hi_d   = hi_we ? wdata : commit ? res_hi : hi_q;
        lo_d   = lo_we ? wdata : commit ? res_lo : lo_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= commit;
            cnt_q  <= state_q == S_MUL ? cnt_q + CW'(1) : '0;
        end
        if (accept) begin
            a_q    <= a;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            dz_q   <= b == '0;
        end
    end
    always_ff @(posedge clk) begin
        prod_q[0] <= ax * bx;
        for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end
    assign busy = state_q != S_IDLE;
    assign done = done_q;
`ifdef HILO_FWD_EN
    assign hi = hi_we ? wdata : hi_q;
    assign lo = lo_we ? wdata : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv against an arithmetic model.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;
    logic        clk = 0, reset = 1, start = 0, flush = 0, hi_we = 0, lo_we = 0;
    muldiv_op_t  op = MULT;
    logic [31:0] a = 0, b = 0, wdata = 0, hi, lo;
    logic        busy, done;
    int          checks = 0, errors = 0;

    hilo_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int     q, r;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            MULT:  return sx * sy;
            MULTU: return {32'd0, x} * {32'd0, y};
            DIV: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            DIVU: return y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: return 64'd0;
        endcase
    endfunction

    task automatic launch(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 1; nb = 0;
        while (!done && n < 200) begin
            nb += int'(busy);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, need all zero", hi, lo, busy, done);
        end
        reset = 0;
    endtask

    task automatic test_mul;
        logic [31:0] x, y;
        logic [63:0] exp;
        muldiv_op_t  o;
        int          n, nb;
        for (int i = 0; i < 12; i++) begin
            o = (i % 2) ? MULTU : MULT;
            x = i < 2 ? 32'hFFFFFFFE : $urandom;
            y = i < 2 ? 32'd3 : $urandom;
            exp = model(o, x, y);
            launch(o, x, y);
            wait_done(n, nb);
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL mul%0d op=%s a=%h b=%h: got %h need %h", i, o.name(), x, y, {hi, lo}, exp);
            end
            checks++;
            if (n !== 3 || nb !== 2 || busy !== 0) begin
                errors++;
                $display("FAIL mul_timing%0d: done cycle %0d busy cycles %0d busy=%b, need 3/2/0", i, n, nb, busy);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] xs [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        logic [31:0] ys [5] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1};
        muldiv_op_t  os [5] = '{DIV, DIVU, DIV, DIV, DIVU};
        logic [31:0] x, y;
        logic [63:0] exp;
        muldiv_op_t  o;
        int          n, nb;
        for (int i = 0; i < 13; i++) begin
            if (i < 5) begin
                o = os[i]; x = xs[i]; y = ys[i];
            end else begin
                o = (i % 2) ? DIVU : DIV;
                x = $urandom;
                y = (i % 3 == 0) ? $urandom_range(1, 20) : $urandom;
                if (i % 4 == 0) y = -y;
            end
            exp = model(o, x, y);
            launch(o, x, y);
            wait_done(n, nb);
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL div%0d op=%s a=%h b=%h: got %h need %h", i, o.name(), x, y, {hi, lo}, exp);
            end
            checks++;
            if (n !== 34 || nb !== 33 || busy !== 0) begin
                errors++;
                $display("FAIL div_timing%0d: done cycle %0d busy cycles %0d busy=%b, need 34/33/0", i, n, nb, busy);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int          dones = 0;
        logic [63:0] got = 0;
        launch(DIV, 32'h80000000, 32'hFFFFFFFF);
        repeat (4) @(negedge clk);
        start = 1; op = MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                dones++;
                got = {hi, lo};
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1 || got !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL busy_ignore: dones=%0d result=%h, need 1 and 0000000080000000", dones, got);
        end
    endtask

    task automatic test_flush;
        int dones = 0;
        @(negedge clk);
        hi_we = 1; wdata = 32'h1111;
        @(negedge clk);
        hi_we = 0; lo_we = 1; wdata = 32'h2222;
        @(negedge clk);
        lo_we = 0;
        checks++;
        if (hi !== 32'h1111 || lo !== 32'h2222) begin
            errors++;
            $display("FAIL direct_write: hi=%h lo=%h, need 1111/2222", hi, lo);
        end
        launch(DIV, $urandom, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks++;
        if (busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL flush_div: busy=%b done=%b, need 0/0", busy, done);
        end
        for (int k = 0; k < 40; k++) begin
            dones += int'(done);
            @(negedge clk);
        end
        launch(MULT, 32'd5, 32'd6);
        flush = 1;
        @(negedge clk);
        flush = 0;
        for (int k = 0; k < 4; k++) begin
            dones += int'(done);
            @(negedge clk);
        end
        checks++;
        if (dones !== 0 || hi !== 32'h1111 || lo !== 32'h2222) begin
            errors++;
            $display("FAIL flush_keep: dones=%0d hi=%h lo=%h, need 0/1111/2222", dones, hi, lo);
        end
        start = 1; flush = 1; op = DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 0; flush = 0;
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL flush_start: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_coincident;
        logic [31:0] x, y;
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            x = $urandom; y = $urandom;
            exp = model(MULT, x, y);
            launch(MULT, x, y);
            @(negedge clk);
            wdata = i == 0 ? 32'hABCD : 32'h5678;
            lo_we = i == 0;
            hi_we = i == 1;
            @(negedge clk);
            lo_we = 0; hi_we = 0;
            checks++;
            if (i == 0 ? (lo !== 32'hABCD || hi !== exp[63:32] || done !== 1)
                       : (hi !== 32'h5678 || lo !== exp[31:0] || done !== 1)) begin
                errors++;
                $display("FAIL coincident%0d: hi=%h lo=%h done=%b, product %h", i, hi, lo, done, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x1, y1, x2, y2;
        int          n, nb;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom_range(1, 1000);
        launch(MULTU, x1, y1);
        wait_done(n, nb);
        start = 1; op = DIVU; a = x2; b = y2;
        checks++;
        if ({hi, lo} !== model(MULTU, x1, y1)) begin
            errors++;
            $display("FAIL b2b_first: got %h need %h", {hi, lo}, model(MULTU, x1, y1));
        end
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, need 1", busy);
        end
        wait_done(n, nb);
        checks++;
        if ({hi, lo} !== model(DIVU, x2, y2) || n !== 34 || nb !== 33) begin
            errors++;
            $display("FAIL b2b_second: got %h cycles %0d/%0d, need %h 34/33", {hi, lo}, n, nb, model(DIVU, x2, y2));
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        hi_we = 1; lo_we = 1; wdata = 32'h5A5A;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        launch(DIV, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, need all zero", hi, lo, busy, done);
        end
        for (int k = 0; k < 40; k++) begin
            dones += int'(done);
            @(negedge clk);
        end
        checks++;
        if (dones !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: dones=%0d busy=%b, need 0/0", dones, busy);
        end
    endtask

    task automatic test_fwd;
        logic [31:0] prev;
        @(negedge clk);
        prev = hi;
        hi_we = 1; wdata = 32'd5;
        #1;
        checks++;
`ifdef HILO_FWD_EN
        if (hi !== 32'd5) begin
            errors++;
            $display("FAIL fwd_same_cycle: hi=%h, need 00000005", hi);
        end
`else
        if (hi !== prev) begin
            errors++;
            $display("FAIL no_fwd_same_cycle: hi=%h, need %h", hi, prev);
        end
`endif
        @(negedge clk);
        hi_we = 0;
        checks++;
        if (hi !== 32'd5) begin
            errors++;
            $display("FAIL fwd_next_cycle: hi=%h, need 00000005", hi);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_busy_ignore;
        test_flush;
        test_coincident;
        test_back_to_back;
        test_reset_mid;
        test_fwd;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
